ppu_oam_dma: RTL and testbench
==============================

# ppu_oam_dma

Sprite-attribute DMA engine that acts as the initiator on the PPU register interface. It snoops CPU writes to $4014, halts the CPU, reads 256 bytes from CPU page `{page,8'h00}` and writes each byte to PPU OAMDATA (register 4) over the `ri_*` bus. It sits between the CPU/memory bus and the PPU register-interface inputs, muxed ahead of the CPU's own register accesses.

## Interface

Parameters: none.

Ports:
- `clk_in`  in  1  50MHz system clock
- `nrst_in`  in  1  reset; one clock; asynchronous, active-low
- `cpu_cyc_in`  in  1  one-clk pulse marking the end of each CPU cycle
- `cpu_a_in`  in  16  CPU address bus (snooped)
- `cpu_r_nw_in`  in  1  CPU read/write select (snooped)
- `cpu_d_in`  in  8  CPU write data (snooped)
- `mem_d_in`  in  8  memory read data for the DMA address
- `rdy_out`  out  1  CPU ready; low halts the CPU
- `bus_own_out`  out  1  high while DMA drives `mem_a_out`
- `mem_a_out`  out  16  DMA memory read address
- `ri_sel_out`  out  3  PPU register select
- `ri_ncs_out`  out  1  PPU register chip select (active-low)
- `ri_r_nw_out`  out  1  PPU register read/write select (0 = write)
- `ri_d_out`  out  8  PPU register write data
- `active_out`  out  1  DMA in progress

## Operation

- Trigger: on a clk with `cpu_cyc_in`=1, `cpu_a_in`=16'h4014, `cpu_r_nw_in`=0 and state IDLE:
  - latch `page` <= `cpu_d_in`;
  - go to HALT.
- Triggers seen outside IDLE are ignored.
- Parity flop `odd` toggles on every `cpu_cyc_in` pulse; it resets to 0.
- FSM states: IDLE, HALT, ALIGN, READ, WRITE. Transitions occur only on `cpu_cyc_in` pulses.
  - HALT -> ALIGN if `odd`=1 at that pulse, else -> READ.
  - ALIGN -> READ.
  - READ: `mem_a_out` = {page, idx}. At the pulse, `buf` <= `mem_d_in`; go to WRITE.
  - WRITE: `ri_d_out` = `buf`, `ri_sel_out` = 3'h4, `ri_r_nw_out` = 0. `ri_ncs_out` is low for exactly the one clk on which `cpu_cyc_in`=1.
    - At that pulse: if idx = 8'hFF -> IDLE, else idx <= idx+1 and -> READ.
- `idx` is 8 bits and cleared on trigger. It wraps only at completion, so exactly 256 writes occur.
- Outputs by state:
  - `rdy_out` = 0 in every state except IDLE.
  - `active_out` = ~`rdy_out`.
  - `bus_own_out` = 1 in READ only. `mem_a_out` = 0 outside READ.
- Reset values: `rdy_out` 1, `bus_own_out` 0, `mem_a_out` 0, `ri_sel_out` 0, `ri_ncs_out` 1, `ri_r_nw_out` 1, `ri_d_out` 0, `active_out` 0. Internal: state IDLE, idx 0, `odd` 0, `page` 0, `buf` 0.
- Reset mid-transfer aborts immediately (asynchronous). There is no resume; the OAM holds a partial update.

## Timing

- All outputs are registered. They change on the clk edge at which `cpu_cyc_in`=1 is sampled; `ri_ncs_out` is the exception.
- `ri_ncs_out` is combinational from state WRITE and `cpu_cyc_in`. It is glitch-free because `cpu_cyc_in` is registered upstream.
- `rdy_out` falls on the edge after the trigger pulse. It rises on the edge after the final WRITE pulse.
- Halted CPU cycles: 1 (HALT) + 0/1 (ALIGN) + 512 (READ/WRITE) = 513 when `odd`=0 at HALT, 514 when `odd`=1.
- `mem_d_in` must be valid by the `cpu_cyc_in` pulse that ends the READ cycle.

## Configuration

- `PPU_OAM_DMA_ALIGN_EN`
  - Defined: the ALIGN state is compiled in; 513/514-cycle behaviour as above.
  - Undefined: ALIGN and `odd` are removed; HALT -> READ always; the transfer is always 513 cycles.

## Structure

- Package `ppu_oam_dma_pkg`:
  - state enum;
  - `DMA_TRIG_ADDR` = 16'h4014;
  - `OAMDATA_SEL` = 3'h4;
  - `DMA_LAST_IDX` = 8'hFF.
- Single module; no sub-module. The FSM, counter and parity fit in one body.

## Test plan

- Reset with `cpu_cyc_in` idle -> all outputs at their reset values; `rdy_out`=1 for 10 CPU cycles.
- Write 8'h02 to $4014 at even parity -> 513 halted cycles. The `mem_a_out` sequence is 16'h0200..16'h02FF. There are 256 `ri_ncs_out` pulses with `ri_sel_out`=4, and `ri_d_out` matches memory bytes in order.
- Same trigger at odd parity -> 514 halted cycles. The first READ is delayed one CPU cycle. With the macro undefined, the count is 513.
- A read of $4014, and a write to $4015 -> no transfer; `rdy_out` stays 1.
- `nrst_in` low during WRITE of idx 8'h40 -> `rdy_out`=1 and `ri_ncs_out`=1 with no clock edge. A subsequent trigger with page 8'h07 restarts from 16'h0700.
- A second $4014 write injected while active -> ignored. The transfer completes with the original page.

Source files
------------

// File: rtl/ppu_oam_dma_pkg.sv
// Shared types and constants for the OAM sprite DMA engine.
// The ALIGN state exists only when PPU_OAM_DMA_ALIGN_EN is defined.
package ppu_oam_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
`ifdef PPU_OAM_DMA_ALIGN_EN
    S_ALIGN,
`endif
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  localparam logic [2:0]  OAMDATA_SEL   = 3'h4;
  localparam logic [7:0]  DMA_LAST_IDX  = 8'hFF;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA: snoops $4014 writes, halts the CPU and copies a 256-byte page to OAMDATA.
// Define PPU_OAM_DMA_ALIGN_EN to add the odd-cycle ALIGN state.
module ppu_oam_dma (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic        cpu_cyc_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  mem_d_in,
  output logic        rdy_out,
  output logic        bus_own_out,
  output logic [15:0] mem_a_out,
  output logic [2:0]  ri_sel_out,
  output logic        ri_ncs_out,
  output logic        ri_r_nw_out,
  output logic [7:0]  ri_d_out,
  output logic        active_out
);
  import ppu_oam_dma_pkg::*;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] dbuf_q, dbuf_d;
  logic       trig;

  assign trig = (cpu_a_in == DMA_TRIG_ADDR) && !cpu_r_nw_in;

`ifdef PPU_OAM_DMA_ALIGN_EN
  logic odd_q;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) odd_q <= 1'b0;
    else if (cpu_cyc_in) odd_q <= ~odd_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    dbuf_d  = dbuf_q;
    if (cpu_cyc_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (trig) begin
            page_d  = cpu_d_in;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end
        end
`ifdef PPU_OAM_DMA_ALIGN_EN
        S_HALT:  state_d = odd_q ? S_ALIGN : S_READ;
        S_ALIGN: state_d = S_READ;
`else
        S_HALT:  state_d = S_READ;
`endif
        S_READ: begin
          dbuf_d  = mem_d_in;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == DMA_LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they move with the state.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q     <= S_IDLE;
      idx_q       <= 8'h00;
      page_q      <= 8'h00;
      dbuf_q      <= 8'h00;
      rdy_out     <= 1'b1;
      active_out  <= 1'b0;
      bus_own_out <= 1'b0;
      mem_a_out   <= 16'h0000;
      ri_sel_out  <= 3'h0;
      ri_r_nw_out <= 1'b1;
      ri_d_out    <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      dbuf_q      <= dbuf_d;
      rdy_out     <= (state_d == S_IDLE);
      active_out  <= (state_d != S_IDLE);
      bus_own_out <= (state_d == S_READ);
      mem_a_out   <= (state_d == S_READ) ? {page_d, idx_d} : 16'h0000;
      ri_sel_out  <= (state_d == S_WRITE) ? OAMDATA_SEL : 3'h0;
      ri_r_nw_out <= (state_d != S_WRITE);
      ri_d_out    <= (state_d == S_WRITE) ? dbuf_d : 8'h00;
    end
  end

  // Strobe lasts exactly the cpu_cyc_in clock; cpu_cyc_in is registered upstream.
  assign ri_ncs_out = !((state_q == S_WRITE) && cpu_cyc_in);

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma with a synthetic page-memory model.
// Expected halted-cycle counts follow PPU_OAM_DMA_ALIGN_EN.
module tb_ppu_oam_dma;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cpu_cyc = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic        cpu_r_nw = 1'b1;
  logic [7:0]  cpu_d = 8'h00;
  logic [7:0]  mem_d;
  logic        rdy, bus_own, ri_ncs, ri_r_nw, active;
  logic [15:0] mem_a;
  logic [2:0]  ri_sel;
  logic [7:0]  ri_d;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int halted, nreads, nwrites, addr_err, data_err;
  logic [7:0] exp_page = 8'h00;

  always #10 clk = ~clk;

  function automatic logic [7:0] memb(input logic [15:0] a);
    logic [7:0] lo, hi;
    lo = a[7:0];
    hi = a[15:8];
    return (lo * 8'd7) ^ hi ^ 8'h3C;
  endfunction

  assign mem_d = memb(mem_a);

  ppu_oam_dma dut (
    .clk_in      (clk),
    .nrst_in     (nrst),
    .cpu_cyc_in  (cpu_cyc),
    .cpu_a_in    (cpu_a),
    .cpu_r_nw_in (cpu_r_nw),
    .cpu_d_in    (cpu_d),
    .mem_d_in    (mem_d),
    .rdy_out     (rdy),
    .bus_own_out (bus_own),
    .mem_a_out   (mem_a),
    .ri_sel_out  (ri_sel),
    .ri_ncs_out  (ri_ncs),
    .ri_r_nw_out (ri_r_nw),
    .ri_d_out    (ri_d),
    .active_out  (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    halted = 0;
    nreads = 0;
    nwrites = 0;
    addr_err = 0;
    data_err = 0;
  endtask

  // One CPU cycle: pulse lasts one clk, then two idle clks.
  task automatic cyc(input logic [15:0] a, input logic rnw,
                     input logic [7:0] d);
    logic [7:0] ri, wi;
    @(negedge clk);
    cpu_a = a;
    cpu_r_nw = rnw;
    cpu_d = d;
    cpu_cyc = 1'b1;
    #1;
    ri = nreads[7:0];
    wi = nwrites[7:0];
    if (!rdy) halted++;
    if (bus_own) begin
      if (mem_a !== {exp_page, ri} || nreads > 255) addr_err++;
      nreads++;
    end
    if (!ri_ncs) begin
      if (ri_sel !== 3'h4 || ri_r_nw !== 1'b0 ||
          ri_d !== memb({exp_page, wi}) || nreads != nwrites + 1)
        data_err++;
      nwrites++;
    end
    @(negedge clk);
    cpu_cyc = 1'b0;
    cpu_r_nw = 1'b1;
    cpu_a = 16'h0000;
    @(negedge clk);
    pulses++;
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b1, 8'h00);
  endtask

  task automatic align(input int want);
    if (pulses % 2 != want) idle();
  endtask

  task automatic run_dma(input string tag, input logic [7:0] pg,
                         input bit inject);
    int exp_halt;
    bit done;
`ifdef PPU_OAM_DMA_ALIGN_EN
    exp_halt = 513 + ((pulses + 1) % 2);
`else
    exp_halt = 513;
`endif
    clr();
    exp_page = pg;
    done = 0;
    cyc(16'h4014, 1'b0, pg);
    chk({tag, "_rdy_fall"}, rdy, 0);
    for (int i = 0; i < 600 && !done; i++) begin
      if (inject && i == 10) cyc(16'h4014, 1'b0, 8'h09);
      else idle();
      if (rdy) done = 1;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_halted"}, halted, exp_halt);
    chk({tag, "_reads"}, nreads, 256);
    chk({tag, "_writes"}, nwrites, 256);
    chk({tag, "_addr_err"}, addr_err, 0);
    chk({tag, "_data_err"}, data_err, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  initial begin
    bit hit;
    #35;
    chk("rst_rdy", rdy, 1);
    chk("rst_bus_own", bus_own, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_sel", ri_sel, 0);
    chk("rst_ncs", ri_ncs, 1);
    chk("rst_r_nw", ri_r_nw, 1);
    chk("rst_d", ri_d, 0);
    chk("rst_active", active, 0);
    @(negedge clk);
    nrst = 1'b1;
    pulses = 0;

    clr();
    repeat (10) idle();
    chk("idle_halted", halted, 0);
    chk("idle_rdy", rdy, 1);

    align(1);
    run_dma("even", 8'h02, 0);
    align(0);
    run_dma("odd", 8'h02, 0);

    clr();
    cyc(16'h4014, 1'b1, 8'h02);
    cyc(16'h4015, 1'b0, 8'h02);
    repeat (4) idle();
    chk("notrig_halted", halted, 0);
    chk("notrig_reads", nreads, 0);
    chk("notrig_rdy", rdy, 1);

    run_dma("inject", 8'h05, 1);

    clr();
    exp_page = 8'h03;
    hit = 0;
    cyc(16'h4014, 1'b0, 8'h03);
    for (int i = 0; i < 300 && !hit; i++) begin
      idle();
      if (nwrites == 64 && nreads == 65) hit = 1;
    end
    chk("abort_reach", hit, 1);
    chk("abort_data_err", data_err, 0);
    @(negedge clk);
    cpu_cyc = 1'b1;
    #1;
    chk("abort_ncs_pre", ri_ncs, 0);
    chk("abort_d_pre", ri_d, memb(16'h0340));
    #3;
    nrst = 1'b0;
    #1;
    chk("abort_rdy", rdy, 1);
    chk("abort_ncs", ri_ncs, 1);
    chk("abort_active", active, 0);
    chk("abort_bus_own", bus_own, 0);
    chk("abort_mem_a", mem_a, 0);
    @(negedge clk);
    cpu_cyc = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    pulses = 0;
    idle();
    run_dma("restart", 8'h07, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
